// File: rtl/frv_mem_arbiter_pkg.sv
// frv_mem_arbiter_pkg: FSM state encodings, one-hot grant codes and the IDLE winner pick for frv_mem_arbiter
package frv_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;
  localparam logic [1:0] ARB_GNT_NONE = 2'b00;
  localparam logic [1:0] ARB_GNT_I    = 2'b01;
  localparam logic [1:0] ARB_GNT_D    = 2'b10;
  function automatic logic [1:0] arb_pick(input logic i_cen, input logic d_cen, input logic promote);
    return (promote && i_cen) ? ARB_GNT_I : d_cen ? ARB_GNT_D : i_cen ? ARB_GNT_I : ARB_GNT_NONE;
  endfunction
endpackage

// File: rtl/frv_sat_counter.sv
// frv_sat_counter: counter that holds at LIMIT, flags sat there, clear wins over increment
module frv_sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  logic [WIDTH-1:0] ctr;
  assign sat = ctr == WIDTH'(LIMIT);
  always_ff @(posedge clk) begin
    if (rst || clr) ctr <= '0;
    else if (inc && !sat) ctr <= ctr + WIDTH'(1);
  end
endmodule

// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: shares one memory bus between fetch (imem) and LSU (dmem), dmem first, grant locked while stalled.
// Define FRV_MEM_ARBITER_STARVE_GUARD_EN to promote imem after STARVE_LIMIT stalled cycles.
module frv_mem_arbiter
  import frv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        imem_cen,
  input  logic        imem_wen,
  input  logic [3:0]  imem_strb,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  output logic        imem_stall,
  output logic        imem_error,
  output logic [31:0] imem_rdata,
  input  logic        dmem_cen,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_stall,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata,
  output logic        mem_cen,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_stall,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata
);
  arb_state_t state, state_nxt;
  logic [1:0] gnt;
  logic gnt_i, gnt_d, promote;
  // A busy state pins the grant; reset forces no grant so the bus is quiet
  always_comb begin
    gnt = g_reset ? ARB_GNT_NONE
        : state == ARB_BUSY_I ? ARB_GNT_I
        : state == ARB_BUSY_D ? ARB_GNT_D
        : arb_pick(imem_cen, dmem_cen, promote);
    gnt_i = gnt == ARB_GNT_I;
    gnt_d = gnt == ARB_GNT_D;
  end
  always_comb begin
    state_nxt = state;
    if (state == ARB_IDLE)
      state_nxt = !mem_stall ? ARB_IDLE : gnt_d ? ARB_BUSY_D : gnt_i ? ARB_BUSY_I : ARB_IDLE;
    else if (!mem_stall)
      state_nxt = ARB_IDLE;
  end
  always_ff @(posedge g_clk) begin
    state <= g_reset ? ARB_IDLE : state_nxt;
  end
  always_comb begin
    mem_cen    = gnt_d ? dmem_cen   : gnt_i ? imem_cen   : 1'b0;
    mem_wen    = gnt_d ? dmem_wen   : gnt_i ? imem_wen   : 1'b0;
    mem_strb   = gnt_d ? dmem_strb  : gnt_i ? imem_strb  : 4'h0;
    mem_addr   = gnt_d ? dmem_addr  : gnt_i ? imem_addr  : 32'h0;
    mem_wdata  = gnt_d ? dmem_wdata : gnt_i ? imem_wdata : 32'h0;
    imem_stall = gnt_i ? mem_stall : imem_cen;
    dmem_stall = gnt_d ? mem_stall : dmem_cen;
    imem_error = gnt_i && mem_error && !mem_stall;
    dmem_error = gnt_d && mem_error && !mem_stall;
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
  end
`ifdef FRV_MEM_ARBITER_STARVE_GUARD_EN
  frv_sat_counter #(
    .WIDTH(4),
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk(g_clk),
    .rst(g_reset),
    .inc(imem_cen && imem_stall && state != ARB_BUSY_I),
    .clr(gnt_i && imem_cen && !mem_stall),
    .sat(promote)
  );
`else
  assign promote = 1'b0;
`endif
  a_limit_range: assert property (@(posedge g_clk) STARVE_LIMIT >= 1 && STARVE_LIMIT <= 15);
  a_hold_dmem: assert property (@(posedge g_clk) disable iff (g_reset) state == ARB_BUSY_D |-> dmem_cen);
  a_hold_imem: assert property (@(posedge g_clk) disable iff (g_reset) state == ARB_BUSY_I |-> imem_cen);
endmodule
